// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU with a registered output stage.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SHL) produce a result one cycle
// after accept. MUL runs as an iterative shift-add over WIDTH edges and blocks
// new accepts while it runs. The output register is held under backpressure
// and can be drained and refilled on the same edge.
module pipe_alu #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [2:0]       OPCode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] FinalOut,
    output logic [3:0]       Status,
    output logic             Busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Architectural state
    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     final_out_q, final_out_d;
    logic [3:0]           status_q, status_d;

    // Multiplier state: counter of completed iterations, accumulator,
    // multiplicand pre-shifted into a 2*WIDTH lane, multiplier consumed LSB first
    logic [SW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;

    // Handshake and control
    logic                 out_free;
    logic                 in_ready;
    logic                 accept;
    logic                 alu_load;
    logic                 mul_last;
    logic                 mul_load;

    // Single-cycle datapath
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [2*WIDTH-1:0]   shl_ext;
    logic                 slt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    // Multiplier step result
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH-1:0]     mul_lo;
    logic [WIDTH-1:0]     mul_hi;

    // Extended-width helpers: carry/borrow land in the top bit, and the
    // widened shift leaves the last bit shifted out at position WIDTH
    // (which is naturally 0 for a shift of 0).
    assign sum_ext  = {1'b0, DataA} + {1'b0, DataB};
    assign diff_ext = {1'b0, DataA} - {1'b0, DataB};
    assign shl_ext  = {{WIDTH{1'b0}}, DataA} << DataB[SW-1:0];
    assign slt      = $signed(DataA) < $signed(DataB);

    // One shift-add step; on the final step this is the full product
    assign mul_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    assign mul_lo   = mul_next[WIDTH-1:0];
    assign mul_hi   = mul_next[2*WIDTH-1:WIDTH];

    // Handshake: the output slot is free if empty or being drained this edge
    assign out_free = !out_valid_q || OutReady;
    assign in_ready = (state_q == S_IDLE) && out_free;
    assign accept   = InValid && in_ready;
    assign alu_load = accept && (OPCode != OP_MUL);
    assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign mul_load = mul_last && out_free;

    assign InReady  = in_ready;
    assign OutValid = out_valid_q;
    assign FinalOut = final_out_q;
    assign Status   = status_q;
    assign Busy     = (state_q == S_MUL);

    // Single-cycle result and C/V flags for the presented opcode
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (OPCode)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (DataA[WIDTH-1] == DataB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != DataA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = !diff_ext[WIDTH];
                alu_v   = (DataA[WIDTH-1] != DataB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != DataA[WIDTH-1]);
            end
            OP_AND: alu_res = DataA & DataB;
            OP_OR:  alu_res = DataA | DataB;
            OP_XOR: alu_res = DataA ^ DataB;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            default: alu_res = '0;
        endcase
    end

    // FSM next state: MUL entered on accept of a multiply, left on its load
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && (OPCode == OP_MUL)) state_d = S_MUL;
            S_MUL:  if (mul_load) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplier sequencing; frozen on the last step while the output is full
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (accept && (OPCode == OP_MUL)) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, DataA};
            mplier_d = DataB;
        end else if ((state_q == S_MUL) && !(mul_last && !out_free)) begin
            cnt_d    = cnt_q + CNT_ONE;
            acc_d    = mul_next;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end
    end

    // Output register: load a new result, else drop valid when drained, else hold
    always_comb begin
        final_out_d = final_out_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;
        if (alu_load) begin
            final_out_d = alu_res;
            status_d    = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            out_valid_d = 1'b1;
        end else if (mul_load) begin
            final_out_d = mul_lo;
            status_d    = {mul_lo[WIDTH-1], (mul_lo == '0), 1'b0, (mul_hi != '0)};
            out_valid_d = 1'b1;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset; reset aborts any multiply
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            final_out_q <= '0;
            status_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            final_out_q <= final_out_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu (WIDTH=32): issue side pushes expected
// results, a negedge monitor pops and compares on each output transfer.
module tb_pipe_alu;

    localparam int W = 32;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [W-1:0]  DataA = '0;
    logic [W-1:0]  DataB = '0;
    logic [2:0]    OPCode = '0;
    logic          OutValid;
    logic          OutReady = 1'b1;
    logic [W-1:0]  FinalOut;
    logic [3:0]    Status;
    logic          Busy;

    pipe_alu #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .DataA(DataA), .DataB(DataB), .OPCode(OPCode), .OutValid(OutValid),
        .OutReady(OutReady), .FinalOut(FinalOut), .Status(Status), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] s);
        exp_t e;
        e.res = r;
        e.st  = s;
        return e;
    endfunction

    // Reference model from the opcode definitions using wide plain arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sbv = longint'($signed(b));
        longint          s;
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned full;
        logic [W-1:0]    r = '0;
        bit              c = 0;
        bit              v = 0;
        int              sh;
        case (op)
            3'd0: begin
                full = ua + ub; r = full[W-1:0]; c = (full >> 32) != 0;
                s = sa + sbv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b; c = (ua >= ub);
                s = sa - sbv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sbv) ? 32'd1 : 32'd0;
            3'd6: begin
                sh = int'(b % 32);
                r  = a << sh;
                c  = (sh == 0) ? 1'b0 : ((a >> (32 - sh)) & 32'd1) != 0;
            end
            default: begin
                full = ua * ub; r = full[W-1:0]; v = (full >> 32) != 0;
            end
        endcase
        return mk(r, {r[W-1], (r == 0), c, v});
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    // Present one operation and hold it until accepted (bounded)
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input exp_t e);
        bit rdy;
        int k = 0;
        InValid = 1'b1; OPCode = op; DataA = a; DataB = b;
        do begin
            @(negedge Clock); rdy = InReady;
            @(posedge Clock); k++;
        end while (!rdy && k < 500);
        if (!rdy) begin
            n_checks++;
            $display("FAIL accept_timeout: no accept after %0d cycles, required accept", k);
        end else if (push) begin
            sb.push_back(e);
        end
        #1 InValid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge Clock); k++; end
        while (!(InReady && !OutValid && !Busy) && k < 200);
        if (k >= 200) begin
            n_checks++;
            $display("FAIL idle_timeout: block not idle after %0d cycles", k);
        end
        @(posedge Clock); #1;
    endtask

    // Monitor: compare on every output transfer, and check hold under stall
    initial begin : monitor
        exp_t         e;
        logic [W-1:0] hold_res = '0;
        logic [3:0]   hold_st = '0;
        bit           holding = 0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                holding = 0;
            end else begin
                if (holding) begin
                    check("hold_valid", 64'(OutValid), 64'd1);
                    check("hold_data", 64'({FinalOut, Status}), 64'({hold_res, hold_st}));
                end
                holding  = OutValid && !OutReady;
                hold_res = FinalOut;
                hold_st  = Status;
                if (OutValid && OutReady) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'(OutValid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(FinalOut), 64'(e.res));
                        check("status", 64'(Status), 64'(e.st));
                    end
                end
            end
        end
    end

    // Random backpressure while enabled
    initial begin
        forever begin
            @(posedge Clock); #1;
            if (rand_rdy) OutReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        bit           bad;
        int           k;
        logic [2:0]   op;
        logic [W-1:0] a, b;

        // Reset asserted before any clock edge: outputs clear asynchronously
        #1 Reset = 1'b1;
        #1;
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_finalout", 64'(FinalOut), 64'd0);
        check("rst_status",   64'(Status),   64'd0);
        check("rst_busy",     64'(Busy),     64'd0);
        @(posedge Clock); #1;
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        check("inready_after_rst", 64'(InReady), 64'd1);
        @(posedge Clock); #1;

        // Directed single-cycle vectors
        issue(3'd0, 32'd10, 32'd15, 1, mk(32'd25, 4'b0000));
        issue(3'd1, 32'd10, 32'd15, 1, mk(32'hFFFFFFFB, 4'b1000));
        issue(3'd1, 32'd15, 32'd15, 1, mk(32'd0, 4'b0110));
        issue(3'd0, 32'h7FFFFFFF, 32'd1, 1, mk(32'h80000000, 4'b1001));
        issue(3'd0, 32'hFFFFFFFF, 32'd1, 1, mk(32'd0, 4'b0110));

        // MUL latency window: 32 busy cycles, result on the 32nd edge
        wait_idle();
        issue(3'd7, 32'd10, 32'd15, 1, mk(32'd150, 4'b0000));
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clock);
            if (Busy !== 1'b1 || InReady !== 1'b0 || OutValid !== 1'b0) bad = 1;
        end
        check("mul_busy_window", 64'(bad), 64'd0);
        @(negedge Clock);
        check("mul_done_valid", 64'(OutValid), 64'd1);
        check("mul_done_busy",  64'(Busy),     64'd0);
        @(posedge Clock); #1;
        issue(3'd7, 32'h00010000, 32'h00010000, 1, mk(32'd0, 4'b0101));

        // Backpressure: result 25 held while a SHL waits
        wait_idle();
        OutReady = 1'b0;
        issue(3'd0, 32'd10, 32'd15, 1, mk(32'd25, 4'b0000));
        InValid = 1'b1; OPCode = 3'd6; DataA = 32'd1; DataB = 32'd31;
        bad = 0;
        repeat (3) begin
            @(negedge Clock);
            if (InReady !== 1'b0 || FinalOut !== 32'd25 || OutValid !== 1'b1) bad = 1;
        end
        check("bp_stall", 64'(bad), 64'd0);
        @(posedge Clock); #1 OutReady = 1'b1;
        @(negedge Clock);
        check("bp_inready", 64'(InReady), 64'd1);
        @(posedge Clock);
        sb.push_back(mk(32'h80000000, 4'b1000));
        #1 InValid = 1'b0;

        // Reset in the middle of a MUL aborts it
        wait_idle();
        issue(3'd7, W'($urandom), W'($urandom), 0, mk(32'd0, 4'b0000));
        bad = 0;
        repeat (10) begin
            @(negedge Clock);
            if (OutValid !== 1'b0) bad = 1;
        end
        check("rst_mul_no_out", 64'(bad), 64'd0);
        @(posedge Clock); #1 Reset = 1'b1;
        #1;
        check("rst_mul_busy",     64'(Busy),     64'd0);
        check("rst_mul_outvalid", 64'(OutValid), 64'd0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_mul_inready", 64'(InReady),  64'd1);
        check("rst_mul_noresult", 64'(OutValid), 64'd0);
        @(posedge Clock); #1;
        issue(3'd0, 32'd10, 32'd15, 1, mk(32'd25, 4'b0000));

        // Randomized ops under random backpressure
        wait_idle();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, 1, model(op, a, b));
            k = $urandom_range(0, 2);
            repeat (k) @(posedge Clock);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge Clock); #1 OutReady = 1'b1;

        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(posedge Clock); k++;
        end
        repeat (2) @(negedge Clock);
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; legal values are powers of two, 8 or greater.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 InValid  input  1  operand/opcode presented this cycle.
REQ-005 InReady  output  1  block can accept an operation this cycle.
REQ-006 DataA  input  WIDTH  operand A.
REQ-007 DataB  input  WIDTH  operand B (low $clog2(WIDTH) bits = shift amount for SHL).
REQ-008 OPCode  input  3  operation select.
REQ-009 OutValid  output  1  FinalOut/Status hold an unconsumed result.
REQ-010 OutReady  input  1  consumer takes the result this cycle.
REQ-011 FinalOut  output  WIDTH  registered result.
REQ-012 Status  output  4  registered flags {N,Z,C,V}, bit 3 = N.
REQ-013 Busy  output  1  multi-cycle multiply in progress.

Function
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed A<B gives 1, else 0), 110 SHL (A << DataB[$clog2(WIDTH)-1:0]), 111 MUL (low WIDTH bits of unsigned A*B).
REQ-015 Accept SHALL occur on a rising edge where InValid && InReady; operands and opcode are latched at that edge.
REQ-016 InReady SHALL equal (state==IDLE) && (!OutValid || OutReady); the same-cycle drain and accept case is legal.
REQ-017 The FSM SHALL have states IDLE and MUL. IDLE->MUL on accept of opcode 111. MUL->IDLE on the completion edge (REQ-020). Non-MUL opcodes stay in IDLE.
REQ-018 Non-MUL latency SHALL be 1: the result, Status and OutValid=1 are visible in the cycle after the accept edge.
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per edge, with a 2*WIDTH-bit accumulator. Busy=1 while in MUL.
REQ-020 MUL completion SHALL occur on the WIDTH-th edge after accept, which loads FinalOut/Status and sets OutValid. If OutValid && !OutReady at that edge, the block SHALL hold in MUL with the accumulator frozen until the output register is free.
REQ-021 The output register SHALL hold FinalOut, Status and OutValid stable while OutValid && !OutReady.
REQ-022 OutValid SHALL clear on an edge with OutReady=1 unless a new result loads at that same edge.
REQ-023 N SHALL equal FinalOut[WIDTH-1]. Z SHALL be 1 when FinalOut==0.
REQ-024 C SHALL be set as follows:
- ADD: carry out of bit WIDTH-1.
- SUB: 1 when A>=B unsigned (no borrow).
- SHL: the last bit shifted out, or 0 when the shift amount is 0.
- All other opcodes: 0.
REQ-025 V SHALL be set as follows:
- ADD/SUB: signed overflow.
- MUL: 1 when the upper WIDTH bits of the full product are nonzero.
- All other opcodes: 0.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH. DataB bits above the shift-amount field SHALL be ignored for SHL.
REQ-027 InValid while InReady=0 SHALL be ignored (no accept). The source holds its request.

Reset
REQ-028 While Reset=1, without waiting for a clock edge, the block SHALL set: state=IDLE, OutValid=0, FinalOut=0, Status=4'b0000, Busy=0, and the iteration counter and accumulator to 0.
REQ-029 Reset during MUL SHALL abort the operation and produce no result. InReady=1 in the first cycle after Reset deasserts.
REQ-030 Reset deassertion SHALL take effect at the next rising edge. No accept occurs on an edge where Reset=1.

Verification (WIDTH=32, OutReady=1 unless stated)
REQ-031 ADD A=10, B=15 -> next cycle FinalOut=25, Status=4'b0000, OutValid=1.
REQ-032 SUB A=10, B=15 -> FinalOut=32'hFFFFFFFB, Status=4'b1000. Also SUB A=15, B=15 -> FinalOut=0, Status=4'b0110.
REQ-033 ADD A=32'h7FFFFFFF, B=1 -> FinalOut=32'h80000000, Status=4'b1001. Also ADD A=32'hFFFFFFFF, B=1 -> FinalOut=0, Status=4'b0110.
REQ-034 MUL A=10, B=15 -> Busy=1 and InReady=0 for 32 cycles. FinalOut=150, Status=4'b0000, and OutValid rise exactly 32 edges after accept. Also MUL A=B=32'h00010000 -> FinalOut=0, Status=4'b0101.
REQ-035 Backpressure: OutReady=0 after ADD 10+15, then present SHL A=1, B=31:
- InReady=0 and FinalOut stays 25.
- Raise OutReady: the SHL is accepted on the drain edge; next cycle FinalOut=32'h80000000, Status=4'b1000.
REQ-036 Assert Reset 10 cycles into a MUL -> OutValid stays 0, Busy=0 immediately, InReady=1 after deassertion, and a following ADD 10+15 gives 25.
